seq_alu_muldiv: RTL and testbench
=================================

Name: seq_alu_muldiv

Overview:
- Parametrised, multi-cycle successor to the 8-bit single-cycle ALU.
- Adds three things the old ALU lacks: a WIDTH parameter, iterative unsigned multiply (shift-add) and divide (restoring), and a Start/Busy/Done handshake.
- Sits between the RegFile/ARF operand muxes and the result mux.
- Flags are registered and updated only when an operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  request; sampled on Clock rising edge, honoured only when Busy=0
- FunSel  in  4  operation code, sampled with Start
- A  in  WIDTH  operand A, sampled with Start
- B  in  WIDTH  operand B, sampled with Start
- Busy  out  1  high while a MUL/DIV iteration is in progress
- Done  out  1  one-cycle pulse: results and flags valid
- OutALU  out  WIDTH  result; MUL low half; DIV quotient
- OutHigh  out  WIDTH  MUL high half; DIV remainder; 0 for all other ops
- OutFlag  out  4  {Z,C,N,O}, bit3 = Z
- Err  out  1  divide-by-zero indicator, valid with Done

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Busy, Done, OutALU, OutHigh, OutFlag, Err all 0; iteration counter 0. Any in-flight operation is abandoned and gives no Done.
- States:
  - IDLE: Start=1 accepts A, B, FunSel on the edge. Single-cycle codes stay IDLE. Code 12 goes to MUL, code 13 goes to DIV. Exception: code 13 with B=0 stays IDLE (see divide by zero).
  - MUL / DIV: iterate once per edge. Counter loads WIDTH on accept and decrements each edge. At the edge where it reaches 0: results and flags registered, Done=1, return to IDLE.
- Latency:
  - Single-cycle ops: results registered on the accept edge; Done high for exactly the following cycle.
  - MUL/DIV: Busy=1 for WIDTH cycles after the accept edge; Done=1 in the cycle after Busy falls (accept edge + WIDTH).
- Handshake:
  - Start while Busy=1 is ignored, with no side effects.
  - Start in the Done cycle is accepted, so back-to-back ops are legal.
  - Done never coincides with Busy.
- Outputs hold their last values between operations. Done=0 except in the completion pulse.
- FunSel codes:
  - 0 pass A; 1 pass B
  - 2 ADD A+B; 3 ADC A+B+C, using the stored C flag
  - 4 SUB A-B
  - 5 AND; 6 OR; 7 XOR; 8 NOT A
  - 9 LSL A; 10 LSR A; 11 ASR A
  - 12 MUL; 13 DIV
  - 14 CSL (rotate A left); 15 CSR (rotate A right)
- Flags:
  - Z = (OutALU==0), except MUL, where Z = ({OutHigh,OutALU}==0).
  - N = OutALU[WIDTH-1]; for MUL and DIV, N=0.
  - ADD/ADC: C = carry out of the WIDTH-bit sum; O = signed overflow.
  - SUB: C=1 on borrow (A<B unsigned); O = signed overflow.
  - Shifts and rotates: C = the bit shifted or rotated out; O unchanged.
  - Pass, logic and NOT ops: C and O unchanged.
  - MUL: C = O = (OutHigh!=0).
  - DIV: C=0, O=0.
- MUL: unsigned WIDTH x WIDTH giving a 2*WIDTH product; no truncation.
- DIV: unsigned restoring division; quotient goes to OutALU, remainder to OutHigh.
- Divide by zero (code 13, B=0):
  - No iteration, Busy stays 0; completes like a single-cycle op.
  - OutALU = all ones, OutHigh = A, Err=1, Z=0, C=0, N=0, O=0.
- Err is 0 for every other completion.
- Operand inputs changing during Busy have no effect; operands are latched on accept.

Test Plan (WIDTH=8):
- ADD: A=0xFF, B=0x01, Start 1 cycle → next cycle Done=1, OutALU=0x00, OutHigh=0x00, OutFlag Z=1,C=1,N=0,O=0. Then ADC with A=0x00, B=0x00 → OutALU=0x01, C=0.
- SUB: A=0x80, B=0x01 → OutALU=0x7F, C=0, O=1, N=0. Then SUB A=0x01, B=0x02 → 0xFF, C=1, N=1, O=0.
- MUL: A=0xFF, B=0xFF → Busy high exactly 8 cycles; Done in cycle 9 after accept; OutHigh=0xFE, OutALU=0x01, C=O=1, Z=0. A second Start pulsed mid-Busy is ignored (exactly one Done).
- DIV: A=200, B=7 → OutALU=0x1C, OutHigh=0x04, Err=0, after 8 Busy cycles. Then A=0x55, B=0 → next cycle Done=1, Busy never 1, OutALU=0xFF, OutHigh=0x55, Err=1.
- Rotates/shifts: CSL A=0x81 → 0x03, C=1; ASR A=0x81 → 0xC0, C=1, N=1.
- Reset mid-operation: assert Reset=0 (async, between edges) on cycle 4 of a MUL → immediately Busy=0, Done=0, all outputs 0; release, no Done follows. A fresh ADD 3+4 then gives 0x07.

Source files
------------

// File: rtl/seq_alu_muldiv_if.sv
// Operand/result bundle between the operand muxes, the sequential ALU and the result mux.
interface seq_alu_muldiv_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       fun_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_alu;
  logic [WIDTH-1:0] out_high;
  logic [3:0]       out_flag;
  logic             err;

  modport master (
    output start, fun_sel, a, b,
    input  busy, done, out_alu, out_high, out_flag, err
  );

  modport slave (
    input  start, fun_sel, a, b,
    output busy, done, out_alu, out_high, out_flag, err
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Multi-cycle ALU: single-cycle ops plus shift-add multiply and restoring divide,
// with a start/busy/done handshake and flags {Z,C,N,O} registered on completion.
//
// state   | meaning
// ST_IDLE | waiting for start; single-cycle ops complete from here
// ST_MUL  | shift-add multiply, one partial product per edge
// ST_DIV  | restoring divide, one quotient bit per edge
module seq_alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  seq_alu_muldiv_if.slave io_bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_out_alu;
  logic [WIDTH-1:0] r_out_high;
  logic [3:0]       r_flag;
  logic             r_err;
  logic             r_done;

  logic             w_accept;
  logic             w_div0;
  logic             w_last;
  logic             w_iter_op;

  assign w_accept  = io_bus.start && (r_state == ST_IDLE);
  assign w_div0    = (io_bus.fun_sel == 4'd13) && (io_bus.b == '0);
  assign w_iter_op = (io_bus.fun_sel == 4'd12) || ((io_bus.fun_sel == 4'd13) && !w_div0);
  assign w_last    = (r_cnt == CW'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.start) begin
          if (io_bus.fun_sel == 4'd12)      w_state_nxt = ST_MUL;
          else if (w_iter_op)               w_state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (w_last) w_state_nxt = ST_IDLE;
      default:        w_state_nxt = ST_IDLE;
    endcase
  end

  // MUL: r_hi is the partial product, r_lo the multiplier shifting out.
  // DIV: r_hi is the remainder, r_lo shifts dividend out and quotient in.
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dtrial;
  logic [WIDTH:0]   w_ddiff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  always_comb begin
    w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_dtrial = {r_hi, r_lo[MSB]};
    w_ddiff  = w_dtrial - {1'b0, r_opd};
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == ST_MUL) begin
      w_hi_nxt = w_msum[WIDTH:1];
      w_lo_nxt = {w_msum[0], r_lo[MSB:1]};
    end else if (r_state == ST_DIV) begin
      if (w_ddiff[WIDTH]) begin
        w_hi_nxt = w_dtrial[MSB:0];
        w_lo_nxt = {r_lo[MSB-1:0], 1'b0};
      end else begin
        w_hi_nxt = w_ddiff[MSB:0];
        w_lo_nxt = {r_lo[MSB-1:0], 1'b1};
      end
    end
  end

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_high;
  logic             w_c;
  logic             w_o;
  logic             w_err;
  logic [3:0]       w_flag;
  logic [3:0]       w_mul_flag;
  logic [3:0]       w_div_flag;

  assign w_add = {1'b0, io_bus.a} + {1'b0, io_bus.b}
               + {{WIDTH{1'b0}}, (io_bus.fun_sel == 4'd3) && r_flag[2]};
  assign w_sub = {1'b0, io_bus.a} - {1'b0, io_bus.b};

  always_comb begin
    w_res  = '0;
    w_high = '0;
    w_err  = 1'b0;
    w_c    = r_flag[2];
    w_o    = r_flag[0];
    case (io_bus.fun_sel)
      4'd0:  w_res = io_bus.a;
      4'd1:  w_res = io_bus.b;
      4'd2, 4'd3: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_o   = (io_bus.a[MSB] == io_bus.b[MSB]) && (w_add[MSB] != io_bus.a[MSB]);
      end
      4'd4: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_o   = (io_bus.a[MSB] != io_bus.b[MSB]) && (w_sub[MSB] != io_bus.a[MSB]);
      end
      4'd5:  w_res = io_bus.a & io_bus.b;
      4'd6:  w_res = io_bus.a | io_bus.b;
      4'd7:  w_res = io_bus.a ^ io_bus.b;
      4'd8:  w_res = ~io_bus.a;
      4'd9:  begin w_res = {io_bus.a[MSB-1:0], 1'b0};        w_c = io_bus.a[MSB]; end
      4'd10: begin w_res = {1'b0, io_bus.a[MSB:1]};          w_c = io_bus.a[0];   end
      4'd11: begin w_res = {io_bus.a[MSB], io_bus.a[MSB:1]}; w_c = io_bus.a[0];   end
      4'd13: begin
        w_res  = '1;
        w_high = io_bus.a;
        w_err  = 1'b1;
        w_c    = 1'b0;
        w_o    = 1'b0;
      end
      4'd14: begin w_res = {io_bus.a[MSB-1:0], io_bus.a[MSB]}; w_c = io_bus.a[MSB]; end
      4'd15: begin w_res = {io_bus.a[0], io_bus.a[MSB:1]};     w_c = io_bus.a[0];   end
      default: ;
    endcase
    w_flag = w_err ? 4'b0000 : {(w_res == '0), w_c, w_res[MSB], w_o};
  end

  assign w_mul_flag = {({w_hi_nxt, w_lo_nxt} == '0), (w_hi_nxt != '0), 1'b0, (w_hi_nxt != '0)};
  assign w_div_flag = {(w_lo_nxt == '0), 3'b000};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_opd      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_out_alu  <= '0;
      r_out_high <= '0;
      r_flag     <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_iter_op) begin
          r_cnt <= CW'(WIDTH);
          r_hi  <= '0;
          if (io_bus.fun_sel == 4'd12) begin
            r_opd <= io_bus.a;
            r_lo  <= io_bus.b;
          end else begin
            r_opd <= io_bus.b;
            r_lo  <= io_bus.a;
          end
        end else begin
          r_out_alu  <= w_res;
          r_out_high <= w_high;
          r_flag     <= w_flag;
          r_err      <= w_err;
          r_done     <= 1'b1;
        end
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt - CW'(1);
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        if (w_last) begin
          r_out_alu  <= w_lo_nxt;
          r_out_high <= w_hi_nxt;
          r_flag     <= (r_state == ST_MUL) ? w_mul_flag : w_div_flag;
          r_err      <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign io_bus.busy     = (r_state != ST_IDLE);
  assign io_bus.done     = r_done;
  assign io_bus.out_alu  = r_out_alu;
  assign io_bus.out_high = r_out_high;
  assign io_bus.out_flag = r_flag;
  assign io_bus.err      = r_err;

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Bench for seq_alu_muldiv at WIDTH=8: directed cases plus random ops against an arithmetic model.
module tb_seq_alu_muldiv;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_muldiv_if #(.WIDTH(W)) bus ();
  seq_alu_muldiv #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] m_flag = 4'b0000;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flg;
    logic       err;
    int         lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] pf);
    exp_t e;
    int ua, ub, sa, sb, s, ss, p, cin;
    logic c, o;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    cin = pf[2];
    e.res = 8'h00; e.hi = 8'h00; e.err = 1'b0; e.lat = 0; e.flg = 4'b0;
    c = pf[2]; o = pf[0]; p = 0;
    case (f)
      4'd0: e.res = a;
      4'd1: e.res = b;
      4'd2, 4'd3: begin
        s  = ua + ub + ((f == 4'd3) ? cin : 0);
        ss = sa + sb + ((f == 4'd3) ? cin : 0);
        e.res = 8'(s);
        c = (s > 255);
        o = (ss > 127) || (ss < -128);
      end
      4'd4: begin
        s  = ua - ub;
        ss = sa - sb;
        e.res = 8'(s);
        c = (ua < ub);
        o = (ss > 127) || (ss < -128);
      end
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = a ^ b;
      4'd8: e.res = ~a;
      4'd9:  begin e.res = 8'(ua * 2);            c = (ua >= 128); end
      4'd10: begin e.res = 8'(ua / 2);            c = (ua % 2 == 1); end
      4'd11: begin e.res = 8'(sa >>> 1);          c = (ua % 2 == 1); end
      4'd12: begin
        p = ua * ub;
        e.res = 8'(p % 256);
        e.hi  = 8'(p / 256);
        e.lat = 8;
      end
      4'd13: begin
        if (ub == 0) begin
          e.res = 8'hFF; e.hi = a; e.err = 1'b1;
        end else begin
          e.res = 8'(ua / ub); e.hi = 8'(ua % ub); e.lat = 8;
        end
      end
      4'd14: begin e.res = 8'((ua * 2) % 256 + ua / 128); c = (ua >= 128); end
      default: begin e.res = 8'(ua / 2 + (ua % 2) * 128); c = (ua % 2 == 1); end
    endcase
    if (f == 4'd12)      e.flg = {(p == 0), (e.hi != 0), 1'b0, (e.hi != 0)};
    else if (f == 4'd13) e.flg = e.err ? 4'b0000 : {(e.res == 0), 3'b000};
    else                 e.flg = {(e.res == 0), c, e.res[7], o};
    return e;
  endfunction

  task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b, input bit mid);
    exp_t e;
    int k, nbusy;
    e = model(f, a, b, m_flag);
    @(negedge clk);
    bus.start = 1'b1; bus.fun_sel = f; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.fun_sel = 4'($urandom);
    k = 0; nbusy = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      if (mid && k == 3) begin bus.start = 1'b1; bus.fun_sel = 4'd2; end
      @(posedge clk); #1;
      bus.start = 1'b0;
      k++;
    end
    chk($sformatf("f%0d_done_seen", f), 64'(bus.done), 64'd1);
    chk($sformatf("f%0d_latency", f), 64'(k), 64'(e.lat));
    chk($sformatf("f%0d_busy_cycles", f), 64'(nbusy), 64'(e.lat));
    chk($sformatf("f%0d_busy_at_done", f), 64'(bus.busy), 64'd0);
    chk($sformatf("f%0d_out_alu a=%0h b=%0h", f, a, b), 64'(bus.out_alu), 64'(e.res));
    chk($sformatf("f%0d_out_high a=%0h b=%0h", f, a, b), 64'(bus.out_high), 64'(e.hi));
    chk($sformatf("f%0d_flags a=%0h b=%0h", f, a, b), 64'(bus.out_flag), 64'(e.flg));
    chk($sformatf("f%0d_err", f), 64'(bus.err), 64'(e.err));
    m_flag = e.flg;
    if (mid) begin
      @(posedge clk); #1;
      chk("mid_start_no_second_done", 64'(bus.done), 64'd0);
      chk("mid_start_not_busy", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  64'(bus.busy),     64'd0);
    chk({tag, "_done"},  64'(bus.done),     64'd0);
    chk({tag, "_alu"},   64'(bus.out_alu),  64'd0);
    chk({tag, "_high"},  64'(bus.out_high), 64'd0);
    chk({tag, "_flag"},  64'(bus.out_flag), 64'd0);
    chk({tag, "_err"},   64'(bus.err),      64'd0);
  endtask

  initial begin
    int nd;
    logic [3:0] rf;
    logic [7:0] ra, rb;
    bit rm;
    bus.start = 1'b0; bus.fun_sel = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
    #12;
    chk_zero_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    run_op(4'd2,  8'hFF, 8'h01, 1'b0);
    run_op(4'd3,  8'h00, 8'h00, 1'b0);
    run_op(4'd4,  8'h80, 8'h01, 1'b0);
    run_op(4'd4,  8'h01, 8'h02, 1'b0);
    run_op(4'd12, 8'hFF, 8'hFF, 1'b1);
    run_op(4'd13, 8'd200, 8'd7, 1'b0);
    run_op(4'd13, 8'h55, 8'h00, 1'b0);
    run_op(4'd14, 8'h81, 8'h00, 1'b0);
    run_op(4'd11, 8'h81, 8'h00, 1'b0);
    run_op(4'd12, 8'h00, 8'h37, 1'b0);
    run_op(4'd13, 8'h05, 8'h09, 1'b0);

    // Asynchronous reset in the fourth busy cycle of a multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.fun_sel = 4'd12; bus.a = 8'hFF; bus.b = 8'hFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    m_flag = 4'b0000;
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.done) nd++;
    end
    chk("no_done_after_reset", 64'(nd), 64'd0);
    run_op(4'd2, 8'd3, 8'd4, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      rm = ($urandom_range(0, 3) == 0);
      run_op(rf, ra, rb, rm);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
